ps2_rx: RTL and testbench
=========================

# ps2_rx

PS/2 device-to-host serial receiver. Synchronizes and debounces the raw `ps2_clk`/`ps2_data` lines from the keyboard connector. Deserializes each 11-bit frame (start, 8 data LSB-first, odd parity, stop). Presents the scan-code byte on `data` with a one-cycle `done` strobe; it sits directly upstream of the key-state tracker, which consumes `data`/`done`.

## Interface
- `FILTER_LEN`, 4: consecutive `clk` cycles the synchronized `ps2_clk` must hold a new level before the filtered clock changes.
- `TIMEOUT_CYC`, 10000: `clk` cycles allowed between filtered falling edges inside a frame before abort.
- `clk` input 1: system clock; all logic in this single domain.
- `rst` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock line, asynchronous.
- `ps2_data` input 1: raw PS/2 data line, asynchronous.
- `data` output 8: last correctly received byte; held until the next good frame.
- `done` output 1: one-cycle pulse when `data` has just been updated.
- `parity_err` output 1: one-cycle pulse on a parity failure.
- `frame_err` output 1: one-cycle pulse on a bad stop bit or timeout.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Input conditioning:
  - Both lines pass through 2-flop synchronizers.
  - Synchronized `ps2_clk` feeds a stability filter: the filtered clock takes the new level only after FILTER_LEN consecutive equal samples.
  - A filtered falling edge is the only event that advances the FSM.
  - Data is sampled from the synchronized `ps2_data` in the edge cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: edge with data=0 → DATA; bit count cleared, shift register cleared. Edge with data=1 → ignored, stay IDLE.
  - DATA: each edge shifts the sampled bit in LSB-first. After the 8th bit → PARITY.
  - PARITY: edge captures the parity bit → STOP. Parity is good when the 8 data bits plus the parity bit contain an odd number of ones.
  - STOP: edge samples the stop bit, then → IDLE.
    - stop=1 and parity good: load `data` from the shift register; pulse `done`.
    - stop=0: pulse `frame_err`.
    - Parity bad: pulse `parity_err`.
    - Both errors pulse together if both occur.
    - Any error leaves `data` unchanged and suppresses `done`.
- Timeout:
  - In any non-IDLE state, a counter increments every `clk` and clears on each filtered falling edge.
  - At TIMEOUT_CYC the FSM returns to IDLE, discards the partial byte and pulses `frame_err`.
  - The counter is held at 0 in IDLE.
- Reset values: `data`=0x00; `done`, `parity_err`, `frame_err`, `busy` = 0; FSM in IDLE; synchronizers and filtered clock = 1 (line idle); counters = 0.
- Reset asserted mid-frame: immediate return to reset values. The first frame after release must decode normally.
- `done`, `parity_err` and `frame_err` never stay high longer than one cycle. No back-to-back pulses within one frame.

## Timing
- Latency: `done`/`parity_err`/`frame_err` rise exactly 3+FILTER_LEN `clk` cycles after the raw `ps2_clk` falling edge of the stop bit:
  - 2 cycles synchronizer
  - FILTER_LEN cycles filter
  - 1 cycle output register
- `data` changes in the same cycle `done` rises and is stable from then until the next `done`.
- `busy`:
  - rises 1 cycle after the start-bit edge is detected;
  - falls in the same cycle as the end-of-frame pulse;
  - on timeout, falls in the same cycle as `frame_err`.
- Glitches on `ps2_clk` shorter than FILTER_LEN `clk` cycles are invisible to the FSM.
- Minimum `clk` to PS/2 clock ratio:
  - The `clk` frequency must keep each PS/2 half-period (≥30 µs) longer than FILTER_LEN+2 cycles.
  - The `clk` frequency must keep each full bit period shorter than TIMEOUT_CYC cycles.
  - Design target is a 50 MHz `clk`.
- Timeout fires on the cycle the counter reaches TIMEOUT_CYC. An edge arriving in that same cycle loses; the frame is aborted.

## Test plan
- Valid frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) → exactly one `done` pulse; `data`=0x1C; no error pulses; `busy` low afterwards.
- Back-to-back frames 0xF0 (parity 1), then 0x1C → two `done` pulses; `data` = 0xF0, then 0x1C; each pulse exactly 3+FILTER_LEN cycles after its stop-bit fall.
- Frame 0x1D with parity 0 (correct is 1), after a good 0x1C → `parity_err` one pulse; no `done`; `data` stays 0x1C.
- Frame 0x23 with stop bit 0 → `frame_err` one pulse; no `done`; `data` unchanged. The following valid 0x29 frame decodes → `done`, `data`=0x29.
- Timeout: send start plus 4 data bits, then hold lines high for TIMEOUT_CYC+10 cycles → `frame_err` pulse; `busy` falls. Next valid 0x1B frame → `data`=0x1B.
- Robustness:
  - Inject a `ps2_clk` low glitch of FILTER_LEN-1 cycles mid-bit in a 0x1C frame → `data`=0x1C, no errors.
  - Assert `rst` low mid-frame → all outputs 0 immediately; a subsequent 0x1D frame (parity 1) decodes to `data`=0x1D.

Source files
------------

// File: rtl/ps2_rx.sv
`default_nettype none
// ps2_rx: PS/2 device-to-host receiver with input synchronizers, clock glitch filter,
// 11-bit frame deserializer and per-frame done / parity / framing strobes.
module ps2_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]     sclk_q, sdat_q;
  logic           filt_q, filt_d, filt_prev_q;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [1:0]     state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [7:0]     data_q, data_d;
  logic           done_q, done_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;

  logic fall, sdat, par_ok, timeout;

  assign sdat    = sdat_q[1];
  assign fall    = filt_prev_q & ~filt_q;
  assign par_ok  = ^{shift_q, par_q};
  assign timeout = (state_q != S_IDLE) && (tcnt_q == TCW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q      <= 2'b11;
      sdat_q      <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tcnt_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[0], ps2_clk};
      sdat_q      <= {sdat_q[0], ps2_data};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tcnt_q      <= tcnt_d;
      data_q      <= data_d;
      done_q      <= done_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples at the new level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sclk_q[1] != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) filt_d = sclk_q[1];
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    data_d   = data_q;
    done_d   = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    tcnt_d   = (state_q == S_IDLE || fall) ? '0 : tcnt_q + 1'b1;
    // Timeout wins over an edge arriving in the same cycle.
    if (timeout) begin
      state_d = S_IDLE;
      shift_d = '0;
      ferr_d  = 1'b1;
      tcnt_d  = '0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!sdat) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
            shift_d  = '0;
          end
        end
        S_DATA: begin
          shift_d = {sdat, shift_q[7:1]};
          if (bitcnt_q == 3'd7) state_d  = S_PARITY;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end
        S_PARITY: begin
          par_d   = sdat;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          ferr_d  = !sdat;
          perr_d  = !par_ok;
          if (sdat && par_ok) begin
            data_d = shift_q;
            done_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    data       = data_q;
    done       = done_q;
    parity_err = perr_q;
    frame_err  = ferr_q;
    busy       = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// tb_ps2_rx: directed plus randomized PS/2 frames checked against a frame-level reference model.
module tb_ps2_rx;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 400;
  localparam int LAT         = 3 + FILTER_LEN;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       done, parity_err, frame_err, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic       d, pe, fe;
    logic [7:0] b;
    int         fall;
    bit         lat;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  logic [7:0] exp_data;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .done(done), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every strobe must match the next expected frame outcome.
  always @(negedge clk) begin
    if (rst && (done || parity_err || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, done, parity_err, frame_err}, 32'd0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("done", done, mon_ev.d);
        check("parity_err", parity_err, mon_ev.pe);
        check("frame_err", frame_err, mon_ev.fe);
        check("data_at_pulse", data, mon_ev.b);
        check("busy_at_pulse", busy, 1'b0);
        if (mon_ev.lat) check("latency", cyc - mon_ev.fall, LAT);
      end
    end
  end

  task automatic send_bit(input logic v, input bit glitch, input bit last, input ev_t ev);
    ps2_data = v;
    if (glitch) begin
      cycles(3);
      ps2_clk = 1'b0;
      cycles(FILTER_LEN - 1);
      ps2_clk = 1'b1;
      cycles(10 - 3 - (FILTER_LEN - 1));
    end else begin
      cycles(10);
    end
    if (last) begin
      ev.fall = cyc;
      exp_q.push_back(ev);
    end
    ps2_clk = 1'b0;
    cycles(20);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_bit);
    logic [10:0] bits;
    logic        par, stop;
    ev_t         ev;
    bit          good;
    par  = (($countones(b) % 2) == 0) ^ bad_par;
    stop = !bad_stop;
    bits = {stop, par, b, 1'b0};
    good = (($countones({b, par}) % 2) == 1) && stop;
    ev.d  = good;
    ev.pe = (($countones({b, par}) % 2) == 0);
    ev.fe = !stop;
    ev.b  = good ? b : exp_data;
    ev.lat = 1'b1;
    ev.fall = 0;
    if (good) exp_data = b;
    for (int i = 0; i < 11; i++) begin
      send_bit(bits[i], i == glitch_bit, i == 10, ev);
      if (i == 0) check("busy_mid_frame", busy, 1'b1);
    end
    ps2_data = 1'b1;
    cycles(30);
    check("pending_after_frame", exp_q.size(), 0);
    check("busy_after_frame", busy, 1'b0);
    check("data_after_frame", data, exp_data);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ev_t ev;
    ev = '{d: 1'b0, pe: 1'b0, fe: 1'b0, b: 8'h00, fall: 0, lat: 1'b0};
    send_bit(1'b0, 1'b0, 1'b0, ev);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0, 1'b0, ev);
    ps2_data = 1'b1;
    cycles(10);
    check("busy_partial", busy, 1'b1);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t to_ev;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst      = 1'b1;
    exp_data = 8'h00;
    #2 rst = 1'b0;
    cycles(3);
    check("rst_data", data, 8'h00);
    check("rst_flags", {done, parity_err, frame_err, busy}, 4'b0000);
    rst = 1'b1;
    cycles(5);
    check("post_rst_flags", {done, parity_err, frame_err, busy}, 4'b0000);

    send_frame(8'h1C, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h1C, 0, 0, -1);
    send_frame(8'h1D, 1, 0, -1);
    send_frame(8'h23, 0, 1, -1);
    send_frame(8'h29, 0, 0, -1);

    // Abandoned frame: only the timeout may end it.
    send_partial(8'h55, 4);
    to_ev = '{d: 1'b0, pe: 1'b0, fe: 1'b1, b: exp_data, fall: 0, lat: 1'b0};
    exp_q.push_back(to_ev);
    cycles(TIMEOUT_CYC + 10);
    check("timeout_pending", exp_q.size(), 0);
    check("timeout_busy", busy, 1'b0);
    send_frame(8'h1B, 0, 0, -1);

    send_frame(8'h1C, 0, 0, 4);

    send_partial(8'hA5, 3);
    rst = 1'b0;
    #1;
    exp_data = 8'h00;
    check("midrst_data", data, 8'h00);
    check("midrst_flags", {done, parity_err, frame_err, busy}, 4'b0000);
    cycles(3);
    rst = 1'b1;
    cycles(5);
    send_frame(8'h1D, 0, 0, -1);

    for (int k = 0; k < 30; k++) begin
      send_frame(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
